// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Package  : alu_pkg
// Brief    : Opcodes, job-code field offsets and FSM encoding shared by the
//            ALU job arbiter and its environment.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  // Job code layout: {Q[7:0], M[7:0], opcode[1:0]}
  localparam int Q_MSB  = 17;
  localparam int Q_LSB  = 10;
  localparam int M_MSB  = 9;
  localparam int M_LSB  = 2;
  localparam int OP_MSB = 1;
  localparam int OP_LSB = 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  function automatic logic [1:0] code_op(input logic [17:0] code);
    return code[OP_MSB:OP_LSB];
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_job_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface: alu_job_arbiter_if
// Brief    : Requester job/response channels plus the ALU start/stop bus.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_job_arbiter_if #(
  parameter int CODE_W = 18,
  parameter int REZ_W  = 16
);

  logic [1:0]        req_valid;
  logic [CODE_W-1:0] req_code0;
  logic [CODE_W-1:0] req_code1;
  logic [1:0]        req_ready;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [REZ_W-1:0]  rsp_rez;
  logic              rsp_zero;
  logic              rsp_ovf;
  logic              rsp_err;
  logic [CODE_W-1:0] alu_code;
  logic              alu_start;
  logic              alu_abort;
  logic              alu_stop;
  logic [REZ_W-1:0]  alu_rez;
  logic              alu_zero;
  logic              alu_ovf;
  logic              busy;

  // Environment side: requesters and the ALU
  modport master (
    output req_valid, req_code0, req_code1, rsp_ready,
           alu_stop, alu_rez, alu_zero, alu_ovf,
    input  req_ready, rsp_valid, rsp_rez, rsp_zero, rsp_ovf, rsp_err,
           alu_code, alu_start, alu_abort, busy
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_code0, req_code1, rsp_ready,
           alu_stop, alu_rez, alu_zero, alu_ovf,
    output req_ready, rsp_valid, rsp_rez, rsp_zero, rsp_ovf, rsp_err,
           alu_code, alu_start, alu_abort, busy
  );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter2
// Brief    : Two-way round-robin grant from request valids and last grant.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
  input  wire logic [1:0] i_valid,
  input  wire logic       i_last_grant,
  output logic            o_gnt_valid,
  output logic            o_gnt_idx
);

  always_comb begin
    o_gnt_valid = |i_valid;
    // On contention the requester that was not served last wins
    if (&i_valid) begin
      o_gnt_idx = ~i_last_grant;
    end else begin
      o_gnt_idx = i_valid[1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_job_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_job_arbiter
// Brief    : Round-robin sharing of one ALU between two requesters, one job in
//            flight, with timeout abort and a valid/ready response channel.
// Revision : 1.0 - initial release
// ============================================================================
module alu_job_arbiter
  import alu_pkg::*;
#(
  parameter int CODE_W  = 18,
  parameter int REZ_W   = 16,
  parameter int TMO_CYC = 64
) (
  input  wire logic        clk,
  input  wire logic        rst,
  alu_job_arbiter_if.slave bus
);

  localparam int               CNT_W      = $clog2(TMO_CYC);
  localparam logic [CNT_W-1:0] c_tmo_last = CNT_W'(TMO_CYC - 1);

  state_t            r_state, w_state_nxt;
  logic [CODE_W-1:0] r_code, w_code_nxt;
  logic              r_owner, w_owner_nxt;
  logic              r_last_grant, w_last_nxt;
  logic              r_alu_start, w_start_nxt;
  logic              r_alu_abort, w_abort_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [1:0]        r_rsp_valid, w_rsp_valid_nxt;
  logic [REZ_W-1:0]  r_rez, w_rez_nxt;
  logic              r_zero, w_zero_nxt;
  logic              r_ovf, w_ovf_nxt;
  logic              r_err, w_err_nxt;
  logic              r_busy;
  logic [1:0]        w_req_ready;
  logic              w_gnt_valid;
  logic              w_gnt_idx;

  rr_arbiter2 u_arb (
    .i_valid      (bus.req_valid),
    .i_last_grant (r_last_grant),
    .o_gnt_valid  (w_gnt_valid),
    .o_gnt_idx    (w_gnt_idx)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_code_nxt      = r_code;
    w_owner_nxt     = r_owner;
    w_last_nxt      = r_last_grant;
    w_start_nxt     = 1'b0;
    w_abort_nxt     = 1'b0;
    w_cnt_nxt       = r_cnt;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rez_nxt       = r_rez;
    w_zero_nxt      = r_zero;
    w_ovf_nxt       = r_ovf;
    w_err_nxt       = r_err;
    w_req_ready     = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (w_gnt_valid) begin
          w_req_ready[w_gnt_idx] = 1'b1;
          w_code_nxt  = w_gnt_idx ? bus.req_code1 : bus.req_code0;
          w_owner_nxt = w_gnt_idx;
          w_last_nxt  = w_gnt_idx;
          w_start_nxt = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Counter reads 0 during ISSUE, so the first WAIT cycle sees 1
        w_cnt_nxt   = CNT_W'(1);
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (bus.alu_stop) begin
          w_rez_nxt       = bus.alu_rez;
          w_zero_nxt      = bus.alu_zero;
          w_ovf_nxt       = bus.alu_ovf;
          w_err_nxt       = 1'b0;
          w_rsp_valid_nxt = r_owner ? 2'b10 : 2'b01;
          w_state_nxt     = S_RESP;
        end else if (r_cnt == c_tmo_last) begin
          w_abort_nxt     = 1'b1;
          w_rez_nxt       = '0;
          w_zero_nxt      = 1'b0;
          w_ovf_nxt       = 1'b0;
          w_err_nxt       = 1'b1;
          w_rsp_valid_nxt = r_owner ? 2'b10 : 2'b01;
          w_state_nxt     = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready[r_owner]) begin
          w_rsp_valid_nxt = 2'b00;
          w_state_nxt     = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_code       <= '0;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_alu_start  <= 1'b0;
      r_alu_abort  <= 1'b0;
      r_cnt        <= '0;
      r_rsp_valid  <= 2'b00;
      r_rez        <= '0;
      r_zero       <= 1'b0;
      r_ovf        <= 1'b0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_code       <= w_code_nxt;
      r_owner      <= w_owner_nxt;
      r_last_grant <= w_last_nxt;
      r_alu_start  <= w_start_nxt;
      r_alu_abort  <= w_abort_nxt;
      r_cnt        <= w_cnt_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_rez        <= w_rez_nxt;
      r_zero       <= w_zero_nxt;
      r_ovf        <= w_ovf_nxt;
      r_err        <= w_err_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rez   = r_rez;
  assign bus.rsp_zero  = r_zero;
  assign bus.rsp_ovf   = r_ovf;
  assign bus.rsp_err   = r_err;
  assign bus.alu_code  = r_code;
  assign bus.alu_start = r_alu_start;
  assign bus.alu_abort = r_alu_abort;
  assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_alu_job_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_job_arbiter
// Brief    : Scoreboard bench for alu_job_arbiter with a behavioural ALU stub.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_job_arbiter;
  import alu_pkg::*;

  typedef struct packed {
    logic [1:0]  vld;
    logic [15:0] rez;
    logic        zero;
    logic        ovf;
    logic        err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   stub_lat = 9;
  bit   stub_never = 1'b0;
  int   stub_cnt = 0;
  rsp_t stub_r;
  rsp_t exp_q[$];

  alu_job_arbiter_if #(.CODE_W(18), .REZ_W(16)) bus ();

  alu_job_arbiter #(.CODE_W(18), .REZ_W(16), .TMO_CYC(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic rsp_t model(input logic [17:0] code, input int owner);
    rsp_t r;
    logic [7:0] q;
    logic [7:0] m;
    logic [8:0] s;
    q = code[Q_MSB:Q_LSB];
    m = code[M_MSB:M_LSB];
    r = '0;
    r.vld = (owner == 1) ? 2'b10 : 2'b01;
    case (code_op(code))
      OP_ADD: begin s = {1'b0, q} + {1'b0, m}; r.rez = {8'h00, s[7:0]}; r.ovf = s[8]; end
      OP_SUB: begin s = {1'b0, q} - {1'b0, m}; r.rez = {8'h00, s[7:0]}; r.ovf = s[8]; end
      OP_MUL: r.rez = 16'(q * m);
      default: r.rez = (m == 8'd0) ? {q, 8'hFF} : {q % m, q / m};
    endcase
    r.zero = (r.rez == 16'h0000);
    return r;
  endfunction

  // ALU stub: stop strobe stub_lat cycles after the start pulse, junk otherwise
  always @(negedge clk) begin
    bus.alu_stop = 1'b0;
    bus.alu_rez  = 16'hDEAD;
    bus.alu_zero = 1'b1;
    bus.alu_ovf  = 1'b1;
    if (bus.alu_abort) stub_cnt = 0;
    if (stub_cnt > 0) begin
      stub_cnt = stub_cnt - 1;
      if (stub_cnt == 0) begin
        stub_r       = model(bus.alu_code, 0);
        bus.alu_stop = 1'b1;
        bus.alu_rez  = stub_r.rez;
        bus.alu_zero = stub_r.zero;
        bus.alu_ovf  = stub_r.ovf;
      end
    end
    if (bus.alu_start) stub_cnt = stub_never ? 0 : stub_lat;
  end

  task automatic apply_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_accept(output int who, output bit ok, output int acc);
    ok = 1'b0; who = -1; acc = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      #1;
      if ((bus.req_ready & bus.req_valid) != 2'b00) begin
        ok = 1'b1; who = bus.req_ready[1] ? 1 : 0; acc = cyc;
      end
      @(negedge clk);
    end
  endtask

  task automatic submit(input int idx, input logic [17:0] code,
                        output int who, output bit ok, output int acc);
    if (idx == 0) bus.req_code0 = code; else bus.req_code1 = code;
    bus.req_valid[idx] = 1'b1;
    wait_accept(who, ok, acc);
    bus.req_valid[idx] = 1'b0;
  endtask

  task automatic take_rsp(output rsp_t act, output rsp_t exp, output bit ok, output int rcyc);
    ok = 1'b0; act = '0; exp = '0; rcyc = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (bus.rsp_valid != 2'b00) begin
        ok = 1'b1; rcyc = cyc;
        act = {bus.rsp_valid, bus.rsp_rez, bus.rsp_zero, bus.rsp_ovf, bus.rsp_err};
      end else begin
        @(negedge clk);
      end
    end
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    if (ok) begin
      bus.rsp_ready = act.vld;
      @(negedge clk);
      bus.rsp_ready = 2'b00;
    end
  endtask

  task automatic test_reset();
    logic [63:0] obs;
    repeat (3) @(negedge clk);
    obs = {bus.req_ready, bus.rsp_valid, bus.rsp_rez, bus.rsp_zero, bus.rsp_ovf, bus.rsp_err,
           bus.alu_code, bus.alu_start, bus.alu_abort, bus.busy};
    n_vec++;
    if (obs !== 64'h0) begin n_err++; $display("FAIL reset_outputs: got %h want 0", obs); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int who, acc, rcyc; bit ok; rsp_t act, exp;
    logic [17:0] code;
    code = {8'd3, 8'd5, OP_MUL};
    stub_lat = 9;
    exp_q.push_back(model(code, 0));
    submit(0, code, who, ok, acc);
    n_vec++;
    if (!ok || who !== 0) begin n_err++; $display("FAIL single_accept: got ok=%0d who=%0d want 1/0", ok, who); end
    n_vec++;
    if ({bus.alu_start, bus.busy, bus.alu_code} !== {2'b11, code}) begin
      n_err++; $display("FAIL single_issue: got start=%b busy=%b code=%h want 1 1 %h", bus.alu_start, bus.busy, bus.alu_code, code);
    end
    @(negedge clk);
    n_vec++;
    if (bus.alu_start !== 1'b0) begin n_err++; $display("FAIL single_start_pulse: got %b want 0", bus.alu_start); end
    take_rsp(act, exp, ok, rcyc);
    n_vec++;
    if (!ok || rcyc != acc + 11) begin n_err++; $display("FAIL single_latency: got ok=%0d cyc=%0d want %0d", ok, rcyc, acc + 11); end
    n_vec++;
    if (act !== exp || exp.rez !== 16'h000F) begin n_err++; $display("FAIL single_rsp: got %h want %h", act, exp); end
  endtask

  task automatic test_round_robin();
    int who, acc, rcyc; bit ok; rsp_t act, exp;
    logic [17:0] ca, cb, cc, cd;
    ca = {8'd10, 8'd4, OP_SUB};
    cb = {8'd12, 8'd3, OP_MUL};
    cc = {8'd100, 8'd7, OP_DIV};
    cd = {8'd255, 8'd255, OP_MUL};
    apply_reset();
    stub_lat = 3;
    exp_q.push_back(model(ca, 0));
    exp_q.push_back(model(cb, 1));
    exp_q.push_back(model(cc, 0));
    exp_q.push_back(model(cd, 1));
    bus.req_code0 = ca; bus.req_code1 = cb; bus.req_valid = 2'b11;
    wait_accept(who, ok, acc);
    n_vec++;
    if (!ok || who !== 0) begin n_err++; $display("FAIL rr_first: got who=%0d want 0", who); end
    bus.req_code0 = cc;
    take_rsp(act, exp, ok, rcyc);
    n_vec++;
    if (!ok || act !== exp) begin n_err++; $display("FAIL rr_rsp_a: got %h want %h", act, exp); end
    wait_accept(who, ok, acc);
    n_vec++;
    if (!ok || who !== 1) begin n_err++; $display("FAIL rr_second: got who=%0d want 1", who); end
    bus.req_code1 = cd;
    take_rsp(act, exp, ok, rcyc);
    n_vec++;
    if (!ok || act !== exp) begin n_err++; $display("FAIL rr_rsp_b: got %h want %h", act, exp); end
    wait_accept(who, ok, acc);
    n_vec++;
    if (!ok || who !== 0) begin n_err++; $display("FAIL rr_third: got who=%0d want 0", who); end
    bus.req_valid[0] = 1'b0;
    take_rsp(act, exp, ok, rcyc);
    n_vec++;
    if (!ok || act !== exp) begin n_err++; $display("FAIL rr_rsp_c: got %h want %h", act, exp); end
    wait_accept(who, ok, acc);
    bus.req_valid[1] = 1'b0;
    n_vec++;
    if (!ok || who !== 1) begin n_err++; $display("FAIL rr_fourth: got who=%0d want 1", who); end
    take_rsp(act, exp, ok, rcyc);
    n_vec++;
    if (!ok || act !== exp) begin n_err++; $display("FAIL rr_rsp_d: got %h want %h", act, exp); end
  endtask

  task automatic test_timeout();
    int who, acc, rcyc, ab_cyc; bit ok, seen; rsp_t act, exp, tmo;
    logic [17:0] code;
    code = {8'd9, 8'd2, OP_DIV};
    stub_never = 1'b1;
    tmo = '0; tmo.vld = 2'b01; tmo.err = 1'b1;
    exp_q.push_back(tmo);
    submit(0, code, who, ok, acc);
    seen = 1'b0; ab_cyc = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (bus.alu_abort) begin seen = 1'b1; ab_cyc = cyc; end
      else @(negedge clk);
    end
    n_vec++;
    if (!seen || ab_cyc != acc + 65) begin n_err++; $display("FAIL tmo_abort_time: got seen=%0d cyc=%0d want %0d", seen, ab_cyc, acc + 65); end
    @(negedge clk);
    n_vec++;
    if (bus.alu_abort !== 1'b0) begin n_err++; $display("FAIL tmo_abort_pulse: got %b want 0", bus.alu_abort); end
    take_rsp(act, exp, ok, rcyc);
    n_vec++;
    if (!ok || act !== exp) begin n_err++; $display("FAIL tmo_rsp: got %h want %h", act, exp); end
    stub_never = 1'b0;
    stub_lat = 5;
    code = {8'd21, 8'd2, OP_MUL};
    exp_q.push_back(model(code, 1));
    submit(1, code, who, ok, acc);
    take_rsp(act, exp, ok, rcyc);
    n_vec++;
    if (!ok || act !== exp) begin n_err++; $display("FAIL tmo_next_job: got %h want %h", act, exp); end
  endtask

  task automatic test_rsp_hold();
    int who, acc, rcyc, bad; bit ok; rsp_t act, exp, snap;
    logic [17:0] c4, c5;
    c4 = {8'd50, 8'd8, OP_ADD};
    c5 = {8'd40, 8'd41, OP_SUB};
    stub_lat = 2;
    exp_q.push_back(model(c4, 0));
    submit(0, c4, who, ok, acc);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (bus.rsp_valid != 2'b00) ok = 1'b1; else @(negedge clk);
    end
    snap = {bus.rsp_valid, bus.rsp_rez, bus.rsp_zero, bus.rsp_ovf, bus.rsp_err};
    bus.req_code1 = c5; bus.req_valid[1] = 1'b1; bus.rsp_ready = 2'b10;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if ({bus.rsp_valid, bus.rsp_rez, bus.rsp_zero, bus.rsp_ovf, bus.rsp_err} !== snap ||
          bus.req_ready !== 2'b00) bad++;
    end
    n_vec++;
    if (!ok || bad != 0) begin n_err++; $display("FAIL hold_stable: got %0d bad cycles ok=%0d want 0", bad, ok); end
    bus.rsp_ready = 2'b01;
    @(negedge clk);
    bus.rsp_ready = 2'b00;
    #1;
    n_vec++;
    if ({bus.rsp_valid, bus.req_ready, bus.busy} !== 5'b00100) begin
      n_err++; $display("FAIL hold_release: got vld=%b rdy=%b busy=%b want 00 10 0", bus.rsp_valid, bus.req_ready, bus.busy);
    end
    exp = exp_q.pop_front();
    n_vec++;
    if (snap !== exp) begin n_err++; $display("FAIL hold_rsp: got %h want %h", snap, exp); end
    exp_q.push_back(model(c5, 1));
    wait_accept(who, ok, acc);
    bus.req_valid[1] = 1'b0;
    take_rsp(act, exp, ok, rcyc);
    n_vec++;
    if (!ok || act !== exp) begin n_err++; $display("FAIL hold_next_rsp: got %h want %h", act, exp); end
  endtask

  task automatic test_reset_mid();
    int who, acc, bad; bit ok;
    logic [63:0] obs;
    stub_lat = 20;
    submit(0, {8'd6, 8'd6, OP_MUL}, who, ok, acc);
    repeat (4) @(negedge clk);
    n_vec++;
    if (bus.busy !== 1'b1) begin n_err++; $display("FAIL mid_busy: got %b want 1", bus.busy); end
    #2 rst = 1'b0;
    #1;
    obs = {bus.req_ready, bus.rsp_valid, bus.rsp_rez, bus.rsp_zero, bus.rsp_ovf, bus.rsp_err,
           bus.alu_code, bus.alu_start, bus.alu_abort, bus.busy};
    n_vec++;
    if (obs !== 64'h0) begin n_err++; $display("FAIL mid_async_reset: got %h want 0", obs); end
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 2'b00 || bus.busy !== 1'b0) bad++;
    end
    n_vec++;
    if (bad != 0) begin n_err++; $display("FAIL mid_late_stop: got %0d active cycles want 0", bad); end
  endtask

  task automatic test_flags();
    int who, acc, rcyc; bit ok; rsp_t act, exp;
    logic [17:0] ca, cs;
    ca = {8'd200, 8'd100, OP_ADD};
    cs = {8'd7, 8'd7, OP_SUB};
    stub_lat = 4;
    exp_q.push_back(model(ca, 0));
    submit(0, ca, who, ok, acc);
    take_rsp(act, exp, ok, rcyc);
    n_vec++;
    if (!ok || act !== exp || act.ovf !== 1'b1) begin n_err++; $display("FAIL flags_ovf: got %h want %h", act, exp); end
    exp_q.push_back(model(cs, 1));
    submit(1, cs, who, ok, acc);
    take_rsp(act, exp, ok, rcyc);
    n_vec++;
    if (!ok || act !== exp || act.zero !== 1'b1) begin n_err++; $display("FAIL flags_zero: got %h want %h", act, exp); end
  endtask

  initial begin
    bus.req_valid = 2'b00;
    bus.req_code0 = '0;
    bus.req_code1 = '0;
    bus.rsp_ready = 2'b00;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_rsp_hold();
    test_reset_mid();
    test_flags();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
